apb4_timer_irq_ctrl: RTL and testbench
======================================

# apb4_timer_irq_ctrl

APB4 interrupt controller for the timer bank's `irq_o` vector (two lines per timer: bit 2i is overflow, bit 2i+1 is compare match).
- Edge-captures each source into a pending register, with a per-source enable mask and sticky overrun flags.
- Drives one CPU interrupt line.
- Uses a single in-service slot with claim/complete sequencing, so software services one timer event at a time in fixed priority order.
- Sits beside the timer block on the same APB segment, with its own select.

## Interface
- `IRQ_NUM`, default 4: number of sources, equal to 2 × the timer count. Legal range is 1..16.
- `APB_ADDR_WIDTH`, default 32: APB address width.
- `APB_DATA_WIDTH`, default 32: APB data width. Fixed at 32.
- `pclk_i` in, 1: the single clock.
- `preset_i` in, 1: reset, synchronous and active-high.
- `paddr_i` in, APB_ADDR_WIDTH: register index is taken from `paddr_i[3:2]`; all other bits are ignored.
- `pwdata_i` in, 32: write data.
- `pwrite_i` in, 1: write strobe.
- `psel_i` in, 1: select.
- `penable_i` in, 1: access phase.
- `prdata_o` out, 32: read data.
- `pready_o` out, 1: tied to 1.
- `pslverr_o` out, 1: error response.
- `irq_src_i` in, IRQ_NUM: level inputs from the timer bank's `irq_o`.
- `irq_o` out, 1: interrupt request to the CPU.

## Operation
- **Access definition:** an access is `psel_i && penable_i`. Because `pready_o` is 1, every access completes in one cycle, and each side effect fires exactly once per access.
- **Source capture**
  - `src_q` registers `irq_src_i` every cycle.
  - `rise = irq_src_i & ~src_q`.
  - A rising edge on a source sets that source's pending bit.
  - If the pending bit is already set at that moment, the source's overrun bit is set instead (sticky).
- **Register map**
  - **0x0 STATUS**
    - Read: bits [IRQ_NUM-1:0] are pending; bits [16+IRQ_NUM-1:16] are overrun; all other bits read 0.
    - Write: write-1-to-clear on both fields.
  - **0x4 ENABLE**
    - Read/write on bits [IRQ_NUM-1:0]; upper bits read 0.
    - Enable masks only the claim candidate and `irq_o`. Pending bits still latch for disabled sources.
  - **0x8 CLAIM** (read-only)
    - `cand` is the lowest index i with `pending[i] & enable[i]`.
    - A read in IDLE with a candidate present: returns i+1, clears `pending[i]`, latches `claim_id <= i`, moves to BUSY.
    - A read in IDLE with no candidate, or any read in BUSY: returns 0 with no side effect.
    - A write: ignored, with `pslverr_o = 1`.
  - **0xC COMPLETE** (write-only)
    - A write in BUSY with `pwdata_i[4:0] == claim_id+1` moves to IDLE.
    - A write with any other value, or any write in IDLE: no state change, `pslverr_o = 1`.
    - A read returns `{27'b0, BUSY ? claim_id+1 : 0}`.
- **State machine** (2 states, IDLE and BUSY)
  - IDLE → BUSY on a successful claim.
  - BUSY → IDLE on a matching complete.
  - Reset → IDLE.
- **Interrupt output:** `irq_o = (state == IDLE) && |(pending & enable)`. It is derived combinationally from registers only, with no path from the APB inputs.
- **Simultaneous events on the same bit in one cycle**
  - A set (rise) wins over a W1C clear.
  - A set wins over a claim clear: the bit stays pending, and overrun is not set.
  - An overrun set wins over an overrun W1C clear.
- **`prdata_o`:** equals 0 outside read accesses.
- **`pslverr_o`:** equals 0 except in the error cases listed above.

## Timing
- **Reset:** on any clock edge with `preset_i = 1`, everything returns to its reset value, including mid-claim.
  - pending, overrun, enable and `src_q` are 0; state is IDLE; `claim_id` is 0.
  - During and after reset: `irq_o = 0`, `prdata_o = 0`, `pslverr_o = 0`, `pready_o = 1`.
  - A source held high through reset release is captured once, at the first edge after release.
- **Capture latency:** `irq_src_i` high before edge k with `src_q = 0` means `pending` is set at edge k. `irq_o` is high during cycle k+1 if the source is enabled and the state is IDLE.
- **Pulse handling:** a source high for one cycle is captured. Holding it high produces no further captures until it drops and rises again.
- **Claim timing:** the CLAIM read data is valid in the access cycle. `pending` clears and the state moves to BUSY at the end of that cycle, so `irq_o` drops in the next cycle.
- **Complete timing:** the state returns to IDLE at the edge ending the COMPLETE access. If other enabled bits are pending, `irq_o` reasserts in the next cycle.
- **Error timing:** `pslverr_o` is combinational and asserted during the access cycle only.

## Test plan
- **Reset, then capture:**
  - Stimulus: after reset, write ENABLE = 0xF, then pulse `irq_src_i[1]` for 1 cycle.
  - Response: STATUS reads 0x0000_0002; `irq_o` is 1 from the cycle after the capturing edge.
- **Priority claim/complete:**
  - Stimulus: sources 3 and 1 are pending and enabled.
  - Response: CLAIM returns 2 and `irq_o` drops; a second CLAIM returns 0; COMPLETE with 2 brings `irq_o` back to 1; the next CLAIM returns 4.
- **Overrun:**
  - Stimulus: pulse source 0 twice without claiming.
  - Response: STATUS = 0x0001_0001. Writing 0x0001_0000 to STATUS gives 0x0000_0001.
- **Masking and errors:**
  - Stimulus: ENABLE = 0, source 2 pending.
  - Response: `irq_o` = 0; CLAIM returns 0; COMPLETE 3 in IDLE gives `pslverr_o` = 1.
  - Stimulus: ENABLE = 0x4.
  - Response: `irq_o` = 1 in the next cycle.
- **Simultaneous set and clear:**
  - Stimulus: W1C of bit 1 in the same cycle as a new rise on source 1.
  - Response: pending bit 1 remains 1 and overrun stays 0.
  - Stimulus: a claim of source 1 in the same cycle as a new rise on source 1.
  - Response: CLAIM returns 2 and pending bit 1 is still 1 afterwards.
- **Reset mid-operation:**
  - Stimulus: in BUSY with `claim_id` = 0 and pending = 0x6, assert `preset_i` for 1 cycle.
  - Response: STATUS = 0, ENABLE = 0, `irq_o` = 0, and a COMPLETE write of 1 yields `pslverr_o` = 1.

Source files
------------

// File: rtl/apb4_timer_irq_ctrl.sv
// APB4 interrupt controller for the timer bank: it captures rising edges into pending bits,
// masks them with an enable register, and serves one claim at a time in fixed priority order.
module apb4_timer_irq_ctrl #(
  parameter int IRQ_NUM        = 4,
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32
) (
  input  logic                      pclk_i,
  input  logic                      preset_i,
  input  logic [APB_ADDR_WIDTH-1:0] paddr_i,
  input  logic [APB_DATA_WIDTH-1:0] pwdata_i,
  input  logic                      pwrite_i,
  input  logic                      psel_i,
  input  logic                      penable_i,
  output logic [APB_DATA_WIDTH-1:0] prdata_o,
  output logic                      pready_o,
  output logic                      pslverr_o,
  input  logic [IRQ_NUM-1:0]        irq_src_i,
  output logic                      irq_o
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [IRQ_NUM-1:0] src_q, src_d;
  logic [IRQ_NUM-1:0] pending_q, pending_d;
  logic [IRQ_NUM-1:0] overrun_q, overrun_d;
  logic [IRQ_NUM-1:0] enable_q, enable_d;
  logic [3:0]         claim_id_q, claim_id_d;

  logic                      access;
  logic [1:0]                reg_idx;
  logic [IRQ_NUM-1:0]        rise;
  logic [IRQ_NUM-1:0]        masked;
  logic [IRQ_NUM-1:0]        cand_oh;
  logic [3:0]                cand;
  logic                      cand_valid;
  logic [4:0]                cand_p1;
  logic [4:0]                claim_id_p1;
  logic [IRQ_NUM-1:0]        pending_clr;
  logic [IRQ_NUM-1:0]        overrun_clr;
  logic [IRQ_NUM-1:0]        pending_keep;
  logic [APB_DATA_WIDTH-1:0] rdata;
  logic                      slverr;
  logic                      unused_bits;

  assign access      = psel_i & penable_i;
  assign reg_idx     = paddr_i[3:2];
  assign rise        = irq_src_i & ~src_q;
  assign masked      = pending_q & enable_q;
  assign cand_valid  = |masked;
  assign cand_p1     = {1'b0, cand} + 5'd1;
  assign claim_id_p1 = {1'b0, claim_id_q} + 5'd1;
  assign unused_bits = ^{paddr_i, pwdata_i};

  // Scanning from the top down leaves the lowest pending-and-enabled index selected.
  always_comb begin
    cand_oh = '0;
    cand    = '0;
    for (int i = IRQ_NUM - 1; i >= 0; i--) begin
      if (masked[i]) begin
        cand_oh    = '0;
        cand_oh[i] = 1'b1;
        cand       = i[3:0];
      end
    end
  end

  always_comb begin
    src_d       = irq_src_i;
    enable_d    = enable_q;
    state_d     = state_q;
    claim_id_d  = claim_id_q;
    pending_clr = '0;
    overrun_clr = '0;
    rdata       = '0;
    slverr      = 1'b0;

    if (access && !preset_i) begin
      unique case (reg_idx)
        2'd0: begin
          if (pwrite_i) begin
            pending_clr = pwdata_i[IRQ_NUM-1:0];
            overrun_clr = pwdata_i[16 +: IRQ_NUM];
          end else begin
            rdata[IRQ_NUM-1:0]   = pending_q;
            rdata[16 +: IRQ_NUM] = overrun_q;
          end
        end
        2'd1: begin
          if (pwrite_i) enable_d = pwdata_i[IRQ_NUM-1:0];
          else          rdata[IRQ_NUM-1:0] = enable_q;
        end
        2'd2: begin
          if (pwrite_i) begin
            slverr = 1'b1;
          end else if (state_q == IDLE && cand_valid) begin
            rdata[4:0]  = cand_p1;
            pending_clr = cand_oh;
            claim_id_d  = cand;
            state_d     = BUSY;
          end
        end
        default: begin
          if (pwrite_i) begin
            if (state_q == BUSY && pwdata_i[4:0] == claim_id_p1) state_d = IDLE;
            else                                                 slverr  = 1'b1;
          end else if (state_q == BUSY) begin
            rdata[4:0] = claim_id_p1;
          end
        end
      endcase
    end

    // A rise on a bit being cleared this cycle counts as a fresh set, not an overrun.
    pending_keep = pending_q & ~pending_clr;
    pending_d    = pending_keep | rise;
    overrun_d    = (overrun_q & ~overrun_clr) | (rise & pending_keep);
  end

  always_ff @(posedge pclk_i) begin
    if (preset_i) begin
      state_q    <= IDLE;
      src_q      <= '0;
      pending_q  <= '0;
      overrun_q  <= '0;
      enable_q   <= '0;
      claim_id_q <= '0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      pending_q  <= pending_d;
      overrun_q  <= overrun_d;
      enable_q   <= enable_d;
      claim_id_q <= claim_id_d;
    end
  end

  assign prdata_o  = rdata;
  assign pslverr_o = slverr;
  assign pready_o  = 1'b1;
  assign irq_o     = (state_q == IDLE) && cand_valid;

endmodule

// File: tb/tb_apb4_timer_irq_ctrl.sv
// Scoreboard bench for apb4_timer_irq_ctrl: stimulus queues expected responses and a
// negedge monitor compares them against every APB access and every irq probe cycle.
module tb_apb4_timer_irq_ctrl;

  localparam int IRQ_NUM = 4;
  localparam logic [1:0] ST = 2'd0;
  localparam logic [1:0] EN = 2'd1;
  localparam logic [1:0] CL = 2'd2;
  localparam logic [1:0] CP = 2'd3;

  logic               pclk_i = 1'b0;
  logic               preset_i;
  logic [31:0]        paddr_i;
  logic [31:0]        pwdata_i;
  logic               pwrite_i;
  logic               psel_i;
  logic               penable_i;
  logic [31:0]        prdata_o;
  logic               pready_o;
  logic               pslverr_o;
  logic [IRQ_NUM-1:0] irq_src_i;
  logic               irq_o;

  logic               probe;
  logic [IRQ_NUM-1:0] src_base;

  typedef struct {
    string       name;
    bit          is_probe;
    logic [31:0] rdata;
    bit          slverr;
    bit          irq;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  apb4_timer_irq_ctrl #(
    .IRQ_NUM       (IRQ_NUM),
    .APB_ADDR_WIDTH(32),
    .APB_DATA_WIDTH(32)
  ) dut (
    .pclk_i   (pclk_i),
    .preset_i (preset_i),
    .paddr_i  (paddr_i),
    .pwdata_i (pwdata_i),
    .pwrite_i (pwrite_i),
    .psel_i   (psel_i),
    .penable_i(penable_i),
    .prdata_o (prdata_o),
    .pready_o (pready_o),
    .pslverr_o(pslverr_o),
    .irq_src_i(irq_src_i),
    .irq_o    (irq_o)
  );

  always #5 pclk_i = ~pclk_i;

  // Monitor: every access cycle or probe cycle consumes one queued expectation.
  always @(negedge pclk_i) begin
    if ((psel_i && penable_i) || probe) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_output: DUT output with no queued expectation");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (e.is_probe != probe) begin
          errors++;
          $display("[TB] FAIL %s: cycle kind probe=%0b, required probe=%0b", e.name, probe, e.is_probe);
        end else if (e.is_probe) begin
          if (irq_o !== e.irq) begin
            errors++;
            $display("[TB] FAIL %s: irq_o=%0b, required %0b", e.name, irq_o, e.irq);
          end
        end else if (prdata_o !== e.rdata || pslverr_o !== e.slverr || irq_o !== e.irq || pready_o !== 1'b1) begin
          errors++;
          $display("[TB] FAIL %s: prdata=%h pslverr=%0b irq=%0b pready=%0b, required prdata=%h pslverr=%0b irq=%0b pready=1",
                   e.name, prdata_o, pslverr_o, irq_o, pready_o, e.rdata, e.slverr, e.irq);
        end
      end
    end
  end

  task automatic applyStimulus(input string name, input bit wr, input logic [1:0] idx,
                               input logic [31:0] wdata, input logic [IRQ_NUM-1:0] src_during,
                               input logic [31:0] exp_rdata, input bit exp_slverr, input bit exp_irq);
    exp_t e;
    e.name = name; e.is_probe = 1'b0; e.rdata = exp_rdata; e.slverr = exp_slverr; e.irq = exp_irq;
    exp_q.push_back(e);
    @(posedge pclk_i); #1;
    psel_i = 1'b1; penable_i = 1'b0; pwrite_i = wr;
    paddr_i = {28'hABCD000, idx, 2'b00};
    pwdata_i = wr ? wdata : 32'h0;
    @(posedge pclk_i); #1;
    penable_i = 1'b1;
    irq_src_i = src_base | src_during;
    @(posedge pclk_i); #1;
    psel_i = 1'b0; penable_i = 1'b0; pwrite_i = 1'b0; pwdata_i = 32'h0;
    irq_src_i = src_base;
  endtask

  task automatic apbRead(input string name, input logic [1:0] idx, input logic [31:0] exp_rdata, input bit exp_irq);
    applyStimulus(name, 1'b0, idx, 32'h0, '0, exp_rdata, 1'b0, exp_irq);
  endtask

  task automatic apbWrite(input string name, input logic [1:0] idx, input logic [31:0] wdata,
                          input bit exp_slverr, input bit exp_irq);
    applyStimulus(name, 1'b1, idx, wdata, '0, 32'h0, exp_slverr, exp_irq);
  endtask

  task automatic checkOutput(input string name, input bit exp_irq);
    exp_t e;
    e.name = name; e.is_probe = 1'b1; e.rdata = 32'h0; e.slverr = 1'b0; e.irq = exp_irq;
    exp_q.push_back(e);
    @(posedge pclk_i); #1 probe = 1'b1;
    @(posedge pclk_i); #1 probe = 1'b0;
  endtask

  // One-cycle pulse; irq_o is probed in the pulse cycle and in the cycle after the capturing edge.
  task automatic pulseSrc(input string name, input logic [IRQ_NUM-1:0] mask, input bit exp_before, input bit exp_after);
    exp_t e;
    e.name = {name, "_pre"}; e.is_probe = 1'b1; e.rdata = 32'h0; e.slverr = 1'b0; e.irq = exp_before;
    exp_q.push_back(e);
    e.name = {name, "_post"}; e.irq = exp_after;
    exp_q.push_back(e);
    @(posedge pclk_i); #1;
    irq_src_i = src_base | mask;
    probe = 1'b1;
    @(posedge pclk_i); #1;
    irq_src_i = src_base;
    @(posedge pclk_i); #1 probe = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    preset_i = 1'b1; psel_i = 1'b0; penable_i = 1'b0; pwrite_i = 1'b0;
    paddr_i = 32'h0; pwdata_i = 32'h0; irq_src_i = '0; src_base = '0; probe = 1'b0;
    repeat (2) @(posedge pclk_i);
    #1;

    // Accesses while reset is held must show no response.
    apbWrite("rst_complete_wr", CP, 32'h1, 1'b0, 1'b0);
    apbRead("rst_claim_rd", CL, 32'h0, 1'b0);
    preset_i = 1'b0;
    checkOutput("rst_irq", 1'b0);
    apbRead("rst_status", ST, 32'h0, 1'b0);
    apbRead("rst_enable", EN, 32'h0, 1'b0);
    apbRead("rst_complete_rd", CP, 32'h0, 1'b0);

    // Capture of a single pulse.
    apbWrite("en_all", EN, 32'hF, 1'b0, 1'b0);
    pulseSrc("cap_src1", 4'b0010, 1'b0, 1'b1);
    apbRead("cap_status", ST, 32'h0000_0002, 1'b1);
    apbRead("cap_claim", CL, 32'h2, 1'b1);
    apbWrite("cap_complete", CP, 32'h2, 1'b0, 1'b0);

    // Priority claim/complete.
    pulseSrc("pri_src31", 4'b1010, 1'b0, 1'b1);
    apbRead("pri_claim1", CL, 32'h2, 1'b1);
    checkOutput("pri_irq_busy", 1'b0);
    apbRead("pri_claim_busy", CL, 32'h0, 1'b0);
    apbRead("pri_complete_rd", CP, 32'h2, 1'b0);
    apbWrite("pri_complete1", CP, 32'h2, 1'b0, 1'b0);
    checkOutput("pri_irq_back", 1'b1);
    apbRead("pri_claim3", CL, 32'h4, 1'b1);
    apbWrite("pri_complete_bad", CP, 32'h3, 1'b1, 1'b0);
    apbWrite("pri_complete3", CP, 32'h4, 1'b0, 1'b0);
    checkOutput("pri_irq_idle", 1'b0);

    // Overrun.
    pulseSrc("ovr_first", 4'b0001, 1'b0, 1'b1);
    pulseSrc("ovr_second", 4'b0001, 1'b1, 1'b1);
    apbRead("ovr_status", ST, 32'h0001_0001, 1'b1);
    apbWrite("ovr_clr_ovr", ST, 32'h0001_0000, 1'b0, 1'b1);
    apbRead("ovr_status_clr", ST, 32'h0000_0001, 1'b1);
    apbWrite("ovr_clr_pend", ST, 32'h0000_0001, 1'b0, 1'b1);
    apbRead("ovr_status_empty", ST, 32'h0, 1'b0);

    // Masking and error responses.
    apbWrite("msk_en0", EN, 32'h0, 1'b0, 1'b0);
    pulseSrc("msk_src2", 4'b0100, 1'b0, 1'b0);
    apbRead("msk_status", ST, 32'h4, 1'b0);
    apbRead("msk_claim", CL, 32'h0, 1'b0);
    apbWrite("msk_complete_idle", CP, 32'h3, 1'b1, 1'b0);
    apbWrite("msk_claim_wr", CL, 32'h0, 1'b1, 1'b0);
    apbWrite("msk_en4", EN, 32'h4, 1'b0, 1'b0);
    checkOutput("msk_irq_on", 1'b1);
    apbRead("msk_claim2", CL, 32'h3, 1'b1);
    apbWrite("msk_complete2", CP, 32'h3, 1'b0, 1'b0);
    apbWrite("msk_en_all", EN, 32'hF, 1'b0, 1'b0);

    // Simultaneous set and clear on the same bit.
    pulseSrc("sim_src1", 4'b0010, 1'b0, 1'b1);
    applyStimulus("sim_w1c_rise", 1'b1, ST, 32'h2, 4'b0010, 32'h0, 1'b0, 1'b1);
    apbRead("sim_status_w1c", ST, 32'h2, 1'b1);
    applyStimulus("sim_claim_rise", 1'b0, CL, 32'h0, 4'b0010, 32'h2, 1'b0, 1'b1);
    apbRead("sim_status_claim", ST, 32'h2, 1'b0);
    apbWrite("sim_complete", CP, 32'h2, 1'b0, 1'b0);
    checkOutput("sim_irq_back", 1'b1);
    apbRead("sim_claim_again", CL, 32'h2, 1'b1);
    apbWrite("sim_complete_again", CP, 32'h2, 1'b0, 1'b0);

    // Reset while BUSY with claim_id 0 and pending 0x6.
    pulseSrc("mid_src0", 4'b0001, 1'b0, 1'b1);
    apbRead("mid_claim", CL, 32'h1, 1'b1);
    pulseSrc("mid_src21", 4'b0110, 1'b0, 1'b0);
    apbRead("mid_status", ST, 32'h6, 1'b0);
    @(posedge pclk_i); #1 preset_i = 1'b1;
    @(posedge pclk_i); #1 preset_i = 1'b0;
    checkOutput("mid_irq", 1'b0);
    apbRead("mid_status_rst", ST, 32'h0, 1'b0);
    apbRead("mid_enable_rst", EN, 32'h0, 1'b0);
    apbWrite("mid_complete", CP, 32'h1, 1'b1, 1'b0);

    // A source held high across reset release is captured exactly once.
    src_base = 4'b1000;
    irq_src_i = src_base;
    @(posedge pclk_i); #1 preset_i = 1'b1;
    @(posedge pclk_i); #1;
    @(posedge pclk_i); #1 preset_i = 1'b0;
    apbRead("hold_status", ST, 32'h8, 1'b0);
    apbRead("hold_status2", ST, 32'h8, 1'b0);
    src_base = '0;
    irq_src_i = '0;

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge pclk_i);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
